// File: rtl/round_key_bank.sv
// round_key_bank: registered AES round-key store with sequential writes and indexed 1-cycle reads
// Optional feature macro: ROUND_KEY_DEC_ORDER_EN adds port dec (reverse round-index order)
module round_key_bank #(
  parameter int KEY_WIDTH = 128,
  parameter int NUM_KEYS  = 11,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wr_valid,
  input  logic [KEY_WIDTH-1:0] wr_key,
  output logic                 wr_ready,
  output logic [IDX_W-1:0]     wr_cnt,
  output logic                 loaded,
  input  logic                 rd_req,
  input  logic [IDX_W-1:0]     rd_idx,
`ifdef ROUND_KEY_DEC_ORDER_EN
  input  logic                 dec,
`endif
  output logic [KEY_WIDTH-1:0] rd_key,
  output logic                 rd_valid,
  output logic                 rd_err
);
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  // One extra count bit so that a full bank of 2^IDX_W keys is still representable.
  localparam logic [IDX_W:0] NK = (IDX_W+1)'(NUM_KEYS);
  state_t state, state_nx;
  logic [KEY_WIDTH-1:0] mem [NUM_KEYS];
  logic [IDX_W:0] cnt;
  logic [IDX_W-1:0] p;
  logic wr_acc, in_range, hit, fwd, rd_ok, rd_bad;
  assign wr_cnt = cnt[IDX_W-1:0];
  assign wr_acc = wr_valid && wr_ready && !clear;
  assign in_range = {1'b0, rd_idx} < NK;
`ifdef ROUND_KEY_DEC_ORDER_EN
  assign p = dec ? IDX_W'(NUM_KEYS-1) - rd_idx : rd_idx;
`else
  assign p = rd_idx;
`endif
  // A same-cycle write into the requested slot is forwarded rather than rejected.
  assign hit    = rd_req && in_range && ({1'b0, p} < cnt);
  assign fwd    = rd_req && in_range && wr_acc && ({1'b0, p} == cnt);
  assign rd_ok  = hit || fwd;
  assign rd_bad = rd_req && !rd_ok;
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  // Next state: clear wins, the write that fills the last slot moves to READY
  always_comb begin
    state_nx = state;
    if (clear) state_nx = EMPTY;
    else if (wr_acc) state_nx = (cnt == NK - 1'b1) ? READY : LOADING;
  end
  // Outputs decoded from the registered state
  always_comb begin
    wr_ready = state != READY;
    loaded   = state == READY;
  end
  // Write counter; saturates because writes are only accepted below NUM_KEYS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (wr_acc) cnt <= cnt + 1'b1;
  end
  // Key storage is deliberately unreset; validity lives in cnt alone
  always_ff @(posedge clk) begin
    if (wr_acc) mem[cnt[IDX_W-1:0]] <= wr_key;
  end
  // Registered read port: data or zero on reject, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= !clear && rd_ok;
      rd_err   <= !clear && rd_bad;
      if (!clear && rd_ok) rd_key <= fwd ? wr_key : mem[p];
      else if (!clear && rd_bad) rd_key <= '0;
    end
  end
endmodule

// File: tb/tb_round_key_bank.sv
// tb_round_key_bank: table vectors, corner sequences and random traffic against a queue model
module tb_round_key_bank;
  localparam int NK = 11;
  logic clk = 0, rst_n = 0, clear = 0, wr_valid = 0, rd_req = 0;
  logic [127:0] wr_key = '0;
  logic [3:0] rd_idx = '0;
  logic wr_ready, loaded, rd_valid, rd_err;
  logic [3:0] wr_cnt;
  logic [127:0] rd_key;
`ifdef ROUND_KEY_DEC_ORDER_EN
  logic dec = 0;
`endif
  int vectors = 0, miscompares = 0;
  logic [127:0] keys [$];
  logic [127:0] last_rd = '0;

  round_key_bank dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid), .wr_key(wr_key),
    .wr_ready(wr_ready), .wr_cnt(wr_cnt), .loaded(loaded), .rd_req(rd_req), .rd_idx(rd_idx),
`ifdef ROUND_KEY_DEC_ORDER_EN
    .dec(dec),
`endif
    .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] kv(input int i);
    return {4{32'hA5C3_0000 + 32'(i)}};
  endfunction

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // One clock cycle: predict from the model, drive, then compare after the edge
  task automatic cycle(input bit clr, input bit wv, input logic [127:0] wk,
                       input bit rq, input logic [3:0] idx, input bit dc);
    bit ev, ee, acc;
    int p;
    logic [127:0] ek;
    ev = 0; ee = 0; ek = last_rd;
    if (clr) keys.delete();
    else begin
      acc = wv && keys.size() < NK;
      if (rq) begin
        p = (dc && idx < NK) ? NK - 1 - int'(idx) : int'(idx);
        if (idx >= NK) begin ee = 1; ek = '0; end
        else if (p < keys.size()) begin ev = 1; ek = keys[p]; end
        else if (acc && p == keys.size()) begin ev = 1; ek = wk; end
        else begin ee = 1; ek = '0; end
      end
      if (acc) keys.push_back(wk);
    end
    last_rd = ek;
    @(negedge clk);
    clear = clr; wr_valid = wv; wr_key = wk; rd_req = rq; rd_idx = idx;
`ifdef ROUND_KEY_DEC_ORDER_EN
    dec = dc;
`endif
    @(posedge clk); #1;
    chk("m_rd_valid", 128'(rd_valid), 128'(ev));
    chk("m_rd_err", 128'(rd_err), 128'(ee));
    chk("m_rd_key", rd_key, ek);
    chk("m_wr_cnt", 128'(wr_cnt), 128'(keys.size()));
    chk("m_loaded", 128'(loaded), 128'(keys.size() == NK));
    chk("m_wr_ready", 128'(wr_ready), 128'(keys.size() != NK));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; clear = 0; wr_valid = 0; rd_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    keys.delete(); last_rd = '0;
    #1;
    chk("rst_rd_key", rd_key, '0);
    chk("rst_rd_valid", 128'(rd_valid), '0);
    chk("rst_rd_err", 128'(rd_err), '0);
    chk("rst_wr_cnt", 128'(wr_cnt), '0);
    chk("rst_loaded", 128'(loaded), '0);
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));
  endtask

  typedef struct {
    bit wv; logic [127:0] wk; bit rq; logic [3:0] idx;
    bit ev; bit ee; logic [127:0] ek; int ecnt; bit eld;
  } vec_t;
  vec_t tbl [$];

  initial begin
    for (int i = 0; i < NK; i++) tbl.push_back('{1, kv(i), 0, 0, 0, 0, '0, i + 1, i == NK - 1});
    tbl.push_back('{1, kv(99), 0, 0, 0, 0, '0, NK, 1});
    for (int i = 0; i < NK; i++) tbl.push_back('{0, '0, 1, 4'(i), 1, 0, kv(i), NK, 1});
    tbl.push_back('{0, '0, 1, 4'd11, 0, 1, '0, NK, 1});
    tbl.push_back('{0, '0, 1, 4'd15, 0, 1, '0, NK, 1});
    tbl.push_back('{0, '0, 1, 4'd10, 1, 0, kv(10), NK, 1});

    do_reset();
    foreach (tbl[i]) begin
      cycle(0, tbl[i].wv, tbl[i].wk, tbl[i].rq, tbl[i].idx, 0);
      chk($sformatf("t%0d_valid", i), 128'(rd_valid), 128'(tbl[i].ev));
      chk($sformatf("t%0d_err", i), 128'(rd_err), 128'(tbl[i].ee));
      chk($sformatf("t%0d_key", i), rd_key, tbl[i].ek);
      chk($sformatf("t%0d_cnt", i), 128'(wr_cnt), 128'(tbl[i].ecnt));
      chk($sformatf("t%0d_loaded", i), 128'(loaded), 128'(tbl[i].eld));
      chk($sformatf("t%0d_ready", i), 128'(wr_ready), 128'(!tbl[i].eld));
    end

    // Partial load, read of stored, unwritten and same-cycle-written slots
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, kv(i), 0, 0, 0);
    cycle(0, 0, '0, 1, 4'd2, 0);
    chk("part_k2", rd_key, kv(2));
    cycle(0, 0, '0, 1, 4'd3, 0);
    chk("part_err3", 128'(rd_err), 128'(1));
    cycle(0, 1, kv(3), 1, 4'd3, 0);
    chk("fwd_k3", rd_key, kv(3));
    chk("fwd_valid", 128'(rd_valid), 128'(1));
    chk("fwd_err", 128'(rd_err), '0);

    // Clear in READY beats a concurrent write and read
    for (int i = 4; i < NK; i++) cycle(0, 1, kv(i), 0, 0, 0);
    cycle(0, 0, '0, 1, 4'd5, 0);
    cycle(1, 1, kv(50), 1, 4'd1, 0);
    chk("clr_cnt", 128'(wr_cnt), '0);
    chk("clr_loaded", 128'(loaded), '0);
    chk("clr_valid", 128'(rd_valid), '0);
    chk("clr_err", 128'(rd_err), '0);
    chk("clr_hold", rd_key, kv(5));
    cycle(0, 0, '0, 1, 4'd0, 0);
    chk("clr_rd0_err", 128'(rd_err), 128'(1));

    // Asynchronous reset between edges while loading
    for (int i = 0; i < 5; i++) cycle(0, 1, kv(i), 0, 0, 0);
    cycle(0, 0, '0, 1, 4'd1, 0);
    @(negedge clk);
    rd_req = 1; rd_idx = 4'd2;
    #2 rst_n = 0;
    #1;
    chk("arst_key", rd_key, '0);
    chk("arst_valid", 128'(rd_valid), '0);
    chk("arst_cnt", 128'(wr_cnt), '0);
    chk("arst_ready", 128'(wr_ready), 128'(1));
    @(negedge clk);
    rst_n = 1; rd_req = 0;
    keys.delete(); last_rd = '0;
    @(posedge clk); #1;
    chk("arst_post_cnt", 128'(wr_cnt), '0);
    chk("arst_post_ready", 128'(wr_ready), 128'(1));
    chk("arst_post_valid", 128'(rd_valid), '0);

`ifdef ROUND_KEY_DEC_ORDER_EN
    for (int i = 0; i < NK; i++) cycle(0, 1, kv(i), 0, 0, 0);
    cycle(0, 0, '0, 1, 4'd0, 1);
    chk("dec_0", rd_key, kv(10));
    cycle(0, 0, '0, 1, 4'd10, 1);
    chk("dec_10", rd_key, kv(0));
    cycle(0, 0, '0, 1, 4'd11, 1);
    chk("dec_11_err", 128'(rd_err), 128'(1));
`endif

    // Randomized traffic against the queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit dc;
`ifdef ROUND_KEY_DEC_ORDER_EN
      dc = $urandom_range(0, 1) == 1;
`else
      dc = 0;
`endif
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 9) < 7,
            4'($urandom_range(0, 15)), dc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
